// File: rtl/exec_pkg.sv
// Shared opcode encodings, default sizes and FSM state type for the execute stage.
package exec_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: low WIDTH bits of unsigned a*b after exactly WIDTH steps.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = b_p0[0] ? (acc_p0 + a_p0) : acc_p0;
    end

    // done is asserted in the cycle whose closing edge performs the last step,
    // so result already includes that final partial product
    assign done   = (cnt_p0 == CW'(1));
    assign result = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (start) begin
            cnt_p0 <= CW'(WIDTH);
        end else if (cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - CW'(1);
        end
    end

    // Operand/accumulator datapath carries no reset; cnt_p0 qualifies it
    always_ff @(posedge clk) begin
        if (start) begin
            a_p0   <= a;
            b_p0   <= b;
            acc_p0 <= '0;
        end else if (cnt_p0 != '0) begin
            acc_p0 <= acc_next;
            a_p0   <= a_p0 << 1;
            b_p0   <= b_p0 >> 1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply, writing back to the register bank.
module exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             wen,
    output logic [AW-1:0]    wad,
    output logic [WIDTH-1:0] wdata,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_next;
    logic             accept;
    logic             legal;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [AW-1:0]    rd_p0;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   sh;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign busy      = (state == ST_MUL);
    assign accept    = in_valid && in_ready;
    assign legal     = (op <= OP_MUL);
    assign mul_start = accept && (op == OP_MUL);

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .result (mul_res)
    );

    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        sh       = b[SHW-1:0];
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SLL: alu_res = a << sh;
            OP_SRL: alu_res = a >> sh;
            OP_SRA: alu_res = $unsigned($signed(a) >>> sh);
            OP_SLT: alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (mul_start) rd_p0 <= rd;
    end

    // Writeback register stage: one result per accepted op, or the multiply completion
    always_ff @(posedge clk) begin
        if (rst) begin
            wen    <= 1'b0;
            wad    <= '0;
            wdata  <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
        end else begin
            wen <= 1'b0;
            err <= 1'b0;
            if ((state == ST_MUL) && mul_done) begin
                wen    <= 1'b1;
                wad    <= rd_p0;
                wdata  <= mul_res;
                flag_z <= (mul_res == '0);
                flag_c <= 1'b0;
                flag_v <= 1'b0;
            end else if (accept) begin
                if (!legal) begin
                    err <= 1'b1;
                end else if (op != OP_MUL) begin
                    wen    <= 1'b1;
                    wad    <= rd;
                    wdata  <= alu_res;
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                    flag_v <= alu_v;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU ops, flags, multiply latency, reset abort, illegal opcode.
module tb_exec_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        wen;
    logic [3:0]  wad;
    logic [31:0] wdata;
    logic        flag_z, flag_c, flag_v, busy, err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    exec_stage #(.WIDTH(32), .AW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .a(a), .b(b),
        .wen(wen), .wad(wad), .wdata(wdata),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] d);
        in_valid = 1'b1;
        op = o; a = x; b = y; rd = d;
    endtask

    initial begin
        int wen_seen;
        rst = 1'b1; in_valid = 1'b0; op = '0; rd = '0; a = '0; b = '0;
        step();
        step();
        check("rst_outs", {wen, wad, wdata, flag_z, flag_c, flag_v, busy, err}, '0);
        check("rst_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1'b1);

        // ADD 5+7
        drive(4'd0, 32'd5, 32'd7, 4'd3);
        step();
        in_valid = 1'b0;
        check("add_wen", wen, 1'b1);
        check("add_wad", wad, 4'd3);
        check("add_wdata", wdata, 32'd12);
        check("add_flags", {flag_z, flag_c, flag_v}, 3'b000);
        step();
        check("add_wen_drop", wen, 1'b0);

        // ADD carry wrap
        drive(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd2);
        step();
        in_valid = 1'b0;
        check("add_wrap_data", wdata, 32'd0);
        check("add_wrap_flags", {flag_z, flag_c, flag_v}, 3'b110);

        // SUB overflow, then SUB to zero
        drive(4'd1, 32'h8000_0000, 32'd1, 4'd4);
        step();
        check("sub_ovf_data", wdata, 32'h7FFF_FFFF);
        check("sub_ovf_flags", {flag_z, flag_c, flag_v}, 3'b001);
        drive(4'd1, 32'd4, 32'd4, 4'd4);
        step();
        in_valid = 1'b0;
        check("sub_zero_data", wdata, 32'd0);
        check("sub_zero_flags", {flag_z, flag_c, flag_v}, 3'b100);

        // Back-to-back AND, SRA, SLT
        drive(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd1);
        step();
        check("and_wen", wen, 1'b1);
        check("and_data", {wad, wdata}, {4'd1, 32'hF000_F000});
        drive(4'd8, 32'h8000_0000, 32'd4, 4'd2);
        step();
        check("sra_wen", wen, 1'b1);
        check("sra_data", {wad, wdata}, {4'd2, 32'hF800_0000});
        drive(4'd9, 32'hFFFF_FFFF, 32'd1, 4'd4);
        step();
        in_valid = 1'b0;
        check("slt_wen", wen, 1'b1);
        check("slt_data", {wad, wdata}, {4'd4, 32'd1});
        check("slt_flags", {flag_z, flag_c, flag_v}, 3'b000);
        step();
        check("b2b_wen_drop", wen, 1'b0);

        // MUL with a held ADD behind it
        drive(4'd10, 32'd1234, 32'd5678, 4'd9);
        step();
        drive(4'd0, 32'd1, 32'd2, 4'd5);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("mul_busy_%0d", i), {busy, in_ready, wen}, 3'b100);
            step();
        end
        check("mul_wen", wen, 1'b1);
        check("mul_result", {wad, wdata}, {4'd9, 32'd7006652});
        check("mul_flags", {flag_z, flag_c, flag_v}, 3'b000);
        check("mul_done_ctl", {busy, in_ready}, 2'b01);
        step();
        in_valid = 1'b0;
        check("held_add", {wen, wad, wdata}, {1'b1, 4'd5, 32'd3});

        // Reset 10 cycles into a MUL
        drive(4'd10, 32'd3, 32'd3, 4'd7);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        check("midrst_outs", {wen, wad, wdata, flag_z, flag_c, flag_v, busy, err}, '0);
        rst = 1'b0;
        #1;
        check("midrst_ready", in_ready, 1'b1);
        wen_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wen) wen_seen++;
        end
        check("midrst_no_wen", wen_seen, 0);

        // Illegal opcode then normal ADD
        drive(4'd15, 32'd1, 32'd1, 4'd6);
        step();
        check("illegal_err", {err, wen}, 2'b10);
        drive(4'd0, 32'd10, 32'd20, 4'd6);
        step();
        in_valid = 1'b0;
        check("after_illegal", {err, wen, wad, wdata}, {1'b0, 1'b1, 4'd6, 32'd30});
        step();
        check("after_illegal_drop", {err, wen}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
